// File: rtl/bsg_alu_rr_sched.sv
// bsg_alu_rr_sched
//
// Round-robin scheduler that shares one combinational bsg_alu among els_p requesters.
// Each cycle it picks one valid requester and steers that requester's op/a/b onto the ALU.
// The ALU result, tagged with the requester index, is captured in a one-entry output
// register that a valid/yumi handshake drains.
//
// Ports:
//   clk_i          clock, all state updates on posedge
//   reset_i        synchronous active-high reset
//   v_i            per-requester request valid
//   op_i           per-requester ALU control, requester i at [2i+1:2i]
//   a_i, b_i       per-requester operands, requester i at slice i
//   yumi_o         one-hot, request consumed this cycle
//   alu_control_o  to bsg_alu control
//   alu_a_o        to bsg_alu a
//   alu_b_o        to bsg_alu b
//   alu_res_i      from bsg_alu res
//   v_o            output register holds a result
//   res_o          registered result
//   id_o           index of the requester that produced res_o
//   yumi_i         consumer takes res_o this cycle
module bsg_alu_rr_sched #(
  parameter int unsigned width_p = 4,
  parameter int unsigned els_p = 2,
  localparam int unsigned id_width_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [2*els_p-1:0]         op_i,
  input  logic [width_p*els_p-1:0]   a_i,
  input  logic [width_p*els_p-1:0]   b_i,
  output logic [els_p-1:0]           yumi_o,
  output logic [1:0]                 alu_control_o,
  output logic [width_p-1:0]         alu_a_o,
  output logic [width_p-1:0]         alu_b_o,
  input  logic [width_p-1:0]         alu_res_i,
  output logic                       v_o,
  output logic [width_p-1:0]         res_o,
  output logic [id_width_lp-1:0]     id_o,
  input  logic                       yumi_i
);

  logic                   v_q;
  logic [width_p-1:0]     res_q;
  logic [id_width_lp-1:0] id_q;
  logic [id_width_lp-1:0] last_q;

  logic [id_width_lp-1:0] grant;
  logic [id_width_lp:0]   cand;
  logic                   any_v;
  logic                   ready;
  logic                   accept;

  // Search upward from last_q+1, wrapping modulo els_p; first valid requester wins.
  always_comb begin
    grant = '0;
    any_v = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= els_p; k++) begin
      cand = {1'b0, last_q} + (id_width_lp+1)'(k);
      if (cand >= (id_width_lp+1)'(els_p)) begin
        cand = cand - (id_width_lp+1)'(els_p);
      end
      if (!any_v && v_i[cand[id_width_lp-1:0]]) begin
        any_v = 1'b1;
        grant = cand[id_width_lp-1:0];
      end
    end
  end

  // An illegal yumi_i while empty is harmless here since !v_q already makes us ready.
  assign ready  = !v_q || yumi_i;
  assign accept = any_v && ready && !reset_i;

  // Steering follows the grant even when stalled so the ALU result stays stable.
  always_comb begin
    alu_control_o = '0;
    alu_a_o       = '0;
    alu_b_o       = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      if (any_v && (grant == id_width_lp'(i))) begin
        alu_control_o = op_i[2*i +: 2];
        alu_a_o       = a_i[width_p*i +: width_p];
        alu_b_o       = b_i[width_p*i +: width_p];
      end
    end
  end

  assign yumi_o = accept ? (els_p'(1) << grant) : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q    <= 1'b0;
      res_q  <= '0;
      id_q   <= '0;
      // Requester 0 gets first priority after reset.
      last_q <= id_width_lp'(els_p - 1);
    end else begin
      if (accept) begin
        v_q    <= 1'b1;
        res_q  <= alu_res_i;
        id_q   <= grant;
        last_q <= grant;
      end else if (yumi_i) begin
        v_q <= 1'b0;
      end
    end
  end

  assign v_o   = v_q;
  assign res_o = res_q;
  assign id_o  = id_q;

endmodule

// File: tb/tb_bsg_alu_rr_sched.sv
// Directed bench for bsg_alu_rr_sched with els_p=4, width_p=4 and a small ALU model
// (0:add 1:sub 2:and 3:or). Inputs change 1ns after posedge, checks happen at negedge.
module tb_bsg_alu_rr_sched;

  localparam int unsigned W = 4;
  localparam int unsigned N = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   v_i;
  logic [2*N-1:0] op_i;
  logic [W*N-1:0] a_i;
  logic [W*N-1:0] b_i;
  logic [N-1:0]   yumi_o;
  logic [1:0]     alu_control;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_res;
  logic           v_o;
  logic [W-1:0]   res_o;
  logic [1:0]     id_o;
  logic           yumi_i;

  int n_cmp = 0;
  int n_err = 0;

  bsg_alu_rr_sched #(
    .width_p(W),
    .els_p  (N)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .v_i          (v_i),
    .op_i         (op_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .yumi_o       (yumi_o),
    .alu_control_o(alu_control),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_res_i    (alu_res),
    .v_o          (v_o),
    .res_o        (res_o),
    .id_o         (id_o),
    .yumi_i       (yumi_i)
  );

  // Stand-in for the shared combinational bsg_alu.
  always_comb begin
    alu_res = '0;
    case (alu_control)
      2'd0: alu_res = alu_a + alu_b;
      2'd1: alu_res = alu_a - alu_b;
      2'd2: alu_res = alu_a & alu_b;
      default: alu_res = alu_a | alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // yumi_i is only legal while a result is held.
  always @(negedge clk) begin
    if (!reset && yumi_i) begin
      assert (v_o === 1'b1) else begin
        n_err++;
        $error("FAIL illegal_yumi: observed v_o=%0b while yumi_i=1, required v_o=1", v_o);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Per-requester results with op_i=8'b11100100, a_i=16'h4321, b_i=16'h2222:
  // r0=1+2=3, r1=2-2=0, r2=3&2=2, r3=4|2=6.
  logic [3:0] rr_res [4];
  initial begin
    rr_res[0] = 4'd3;
    rr_res[1] = 4'd0;
    rr_res[2] = 4'd2;
    rr_res[3] = 4'd6;
  end

  initial begin
    reset  = 1'b1;
    v_i    = '0;
    op_i   = '0;
    a_i    = '0;
    b_i    = '0;
    yumi_i = 1'b0;

    // Reset held 3 cycles; requests during reset must not be consumed.
    tick();
    tick();
    v_i  = 4'b1111;
    op_i = 8'b11100100;
    a_i  = 16'h4321;
    b_i  = 16'h2222;
    sample();
    chk("reset_yumi", yumi_o, 4'b0000);
    chk("reset_v", v_o, 1'b0);
    chk("reset_res", res_o, 4'd0);
    chk("reset_id", id_o, 2'd0);
    chk("reset_steer_a", alu_a, 4'd1);
    tick();

    // Round-robin with all requesters valid and the consumer draining every cycle.
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      yumi_i = (k > 0);
      sample();
      chk($sformatf("rr_grant_%0d", k), yumi_o, 4'b0001 << (k % 4));
      if (k > 0) begin
        chk($sformatf("rr_id_%0d", k), id_o, (k - 1) % 4);
        chk($sformatf("rr_res_%0d", k), res_o, rr_res[(k-1)%4]);
      end
      tick();
    end
    // Last accept was requester 3; its result (6) is now held.

    // Backpressure: nothing accepted, output holds.
    yumi_i = 1'b0;
    v_i    = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk($sformatf("bp_yumi_%0d", k), yumi_o, 4'b0000);
      chk($sformatf("bp_id_%0d", k), id_o, 2'd3);
      chk($sformatf("bp_res_%0d", k), res_o, 4'd6);
      tick();
    end
    // Release: drain and accept requester 0 in the same cycle.
    yumi_i = 1'b1;
    sample();
    chk("bp_release_grant", yumi_o, 4'b0001);
    tick();
    yumi_i = 1'b0;
    sample();
    chk("bp_nobubble_v", v_o, 1'b1);
    chk("bp_nobubble_id", id_o, 2'd0);
    chk("bp_nobubble_res", res_o, 4'd3);

    // last grant is 0; a 4-cycle stall must not rotate priority.
    for (int k = 0; k < 4; k++) begin
      if (k > 0) sample();
      chk($sformatf("stall_yumi_%0d", k), yumi_o, 4'b0000);
      tick();
    end
    yumi_i = 1'b1;
    sample();
    chk("stall_release_grant", yumi_o, 4'b0010);
    tick();

    // Sparse: only requester 2 valid.
    v_i = 4'b0100;
    sample();
    chk("sparse_id_prev", id_o, 2'd1);
    chk("sparse_res_prev", res_o, 4'd0);
    chk("sparse_grant_a", yumi_o, 4'b0100);
    tick();
    // last grant is now 2, search wraps 3,0,1,2.
    sample();
    chk("sparse_wrap_grant", yumi_o, 4'b0100);
    chk("sparse_id", id_o, 2'd2);
    chk("sparse_res", res_o, 4'd2);
    tick();
    v_i = 4'b0000;
    sample();
    chk("idle_ctrl", alu_control, 2'd0);
    chk("idle_a", alu_a, 4'd0);
    chk("idle_b", alu_b, 4'd0);
    chk("idle_yumi", yumi_o, 4'b0000);
    chk("idle_v_before_drain", v_o, 1'b1);
    tick();
    yumi_i = 1'b0;
    sample();
    chk("idle_v_after_drain", v_o, 1'b0);
    tick();

    // Reset mid-operation: last grant 2, so requester 0 is accepted first.
    v_i = 4'b0011;
    sample();
    chk("mid_accept", yumi_o, 4'b0001);
    tick();
    // last grant 0; without reset the next grant would be 1.
    reset = 1'b1;
    sample();
    chk("mid_v_held", v_o, 1'b1);
    chk("mid_reset_yumi", yumi_o, 4'b0000);
    tick();
    reset = 1'b0;
    sample();
    chk("mid_post_v", v_o, 1'b0);
    chk("mid_post_grant", yumi_o, 4'b0001);
    tick();
    v_i = 4'b0000;

    // Single request: op add, a=1, b=3 -> 4.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    v_i   = 4'b0001;
    op_i  = 8'b00000000;
    a_i   = 16'h0001;
    b_i   = 16'h0003;
    sample();
    chk("single_grant", yumi_o, 4'b0001);
    chk("single_a", alu_a, 4'd1);
    chk("single_b", alu_b, 4'd3);
    chk("single_ctrl", alu_control, 2'd0);
    tick();
    v_i = 4'b0000;
    sample();
    chk("single_v", v_o, 1'b1);
    chk("single_res", res_o, 4'd4);
    chk("single_id", id_o, 2'd0);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    sample();
    chk("single_drained", v_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
